// File: rtl/usrt_pkg.sv
// Shared definitions for the serial receive path: frame geometry, FIFO entry
// layout and the deframer state encoding.
package usrt_pkg;

  localparam int DATA_BITS = 8;
  localparam int BAUD_W    = 8;
  // Entry layout: {perr, ferr, data[7:0]}
  localparam int ENTRY_W   = DATA_BITS + 2;
  localparam int PERR_BIT  = DATA_BITS + 1;
  localparam int FERR_BIT  = DATA_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // A bit period shorter than two clocks has no usable mid-bit point.
  function automatic logic [BAUD_W-1:0] eff_baud(input logic [BAUD_W-1:0] baud);
    return (baud < BAUD_W'(2)) ? BAUD_W'(2) : baud;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through holding FIFO for received frames. A push into a full
// FIFO is dropped (and flagged) unless a pop frees a slot in the same cycle.
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: valid means head holds the oldest entry; it is removed on any
  // clock edge where valid && ready, and head/valid never depend on ready.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             empty;
  logic             full;
  logic             pop;
  logic             accept;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = valid && ready;
  assign accept = push && (!full || pop);

  assign valid  = !empty;
  // Head is forced to zero while empty so stale entries never leak out.
  assign head   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      overrun <= push && full && !pop;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rx_deframer.sv
// Asynchronous serial receiver: synchronizes the line, deframes start/data/
// parity/stop bits and queues {perr, ferr, data} into a holding FIFO.
module rx_deframer
  import usrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_Pclk,
  input  logic        i_Presetn,
  input  logic [7:0]  i_Baud,
  input  logic        i_Enable,
  input  logic        i_Parity_En,
  input  logic        i_Parity_Odd,
  input  logic        i_Rx_Serial,
  input  logic        i_Ready,
  output logic        o_Valid,
  output logic [7:0]  o_Data,
  output logic        o_Perr,
  output logic        o_Ferr,
  output logic        o_Overrun,
  output rx_state_t   o_State
);

  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            state;
  logic [BAUD_W-1:0]    cnt;
  logic [BAUD_W-1:0]    baud_q;
  logic [BAUD_W-1:0]    half_cnt;
  logic                 bit_end;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en_q;
  logic                 par_odd_q;
  logic                 perr_q;
  logic                 push;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   head;

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  assign half_cnt = baud_q >> 1;
  assign bit_end  = (cnt == baud_q - BAUD_W'(1));

  // The push is taken on the stop-sample edge itself so the frame is visible
  // at the FIFO head in the very next cycle.
  assign push      = i_Enable && (state == ST_STOP) && bit_end;
  assign push_data = {perr_q, ~rx_sync, shreg};

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      baud_q    <= BAUD_W'(2);
      bit_idx   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      perr_q    <= 1'b0;
    end else if (!i_Enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            state     <= ST_START;
            cnt       <= '0;
            baud_q    <= eff_baud(i_Baud);
            par_en_q  <= i_Parity_En;
            par_odd_q <= i_Parity_Odd;
          end
        end
        ST_START: begin
          if (cnt == half_cnt) begin
            cnt     <= '0;
            bit_idx <= '0;
            perr_q  <= 1'b0;
            state   <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cnt    <= '0;
            perr_q <= ^{shreg, rx_sync, par_odd_q};
            state  <= ST_STOP;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + BAUD_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_Pclk),
    .rst_n     (i_Presetn),
    .push      (push),
    .push_data (push_data),
    .ready     (i_Ready),
    .valid     (o_Valid),
    .head      (head),
    .overrun   (o_Overrun)
  );

  assign o_Data  = head[DATA_BITS-1:0];
  assign o_Ferr  = head[FERR_BIT];
  assign o_Perr  = head[PERR_BIT];
  assign o_State = state;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: directed frame table, multi-cycle corner sequences and
// randomized frames checked against a bit-level model of the serial protocol.
module tb_rx_deframer;
  import usrt_pkg::*;

  localparam int DEPTH = 4;

  logic        i_Pclk;
  logic        i_Presetn;
  logic [7:0]  i_Baud;
  logic        i_Enable;
  logic        i_Parity_En;
  logic        i_Parity_Odd;
  logic        i_Rx_Serial;
  logic        i_Ready;
  logic        o_Valid;
  logic [7:0]  o_Data;
  logic        o_Perr;
  logic        o_Ferr;
  logic        o_Overrun;
  rx_state_t   o_State;

  rx_deframer #(.DEPTH(DEPTH)) dut (
    .i_Pclk       (i_Pclk),
    .i_Presetn    (i_Presetn),
    .i_Baud       (i_Baud),
    .i_Enable     (i_Enable),
    .i_Parity_En  (i_Parity_En),
    .i_Parity_Odd (i_Parity_Odd),
    .i_Rx_Serial  (i_Rx_Serial),
    .i_Ready      (i_Ready),
    .o_Valid      (o_Valid),
    .o_Data       (o_Data),
    .o_Perr       (o_Perr),
    .o_Ferr       (o_Ferr),
    .o_Overrun    (o_Overrun),
    .o_State      (o_State)
  );

  // clock / reset
  initial i_Pclk = 1'b0;
  always #5 i_Pclk = ~i_Pclk;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  bit rand_mode = 1'b0;
  logic [ENTRY_W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    int         baud;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[10];

  always @(negedge i_Pclk) if (o_Overrun) ovr_cnt++;

  // scoreboard for the randomized phase: every accepted head must match the model
  always @(negedge i_Pclk) begin
    if (rand_mode && o_Valid && i_Ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rand_unexpected actual=%0h expected=none", {o_Perr, o_Ferr, o_Data});
      end else begin
        logic [ENTRY_W-1:0] e;
        e = exp_q.pop_front();
        if ({o_Perr, o_Ferr, o_Data} !== e) begin
          errors++;
          $display("FAIL rand_entry actual=%0h expected=%0h", {o_Perr, o_Ferr, o_Data}, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks; inputs change just after a rising edge
  task automatic drive_bit(input logic b, input int baud);
    i_Rx_Serial = b;
    repeat (baud) @(posedge i_Pclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(posedge i_Pclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int baud);
    drive_bit(1'b0, baud);
    for (int i = 0; i < 8; i++) drive_bit(d[i], baud);
    if (pen) drive_bit(pbit, baud);
    drive_bit(stop, baud);
    i_Rx_Serial = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge i_Pclk);
      if (o_Valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_valid expected=valid within %0d cycles", name, limit);
    end
  endtask

  task automatic pop_expect(input string name, input logic [7:0] d, input logic perr,
                            input logic ferr);
    bit ok;
    wait_valid(name, 4000, ok);
    if (ok) begin
      check({name, "_data"}, 32'(o_Data), 32'(d));
      check({name, "_perr"}, 32'(o_Perr), 32'(perr));
      check({name, "_ferr"}, 32'(o_Ferr), 32'(ferr));
      i_Ready = 1'b1;
      @(posedge i_Pclk);
      #1;
      i_Ready = 1'b0;
    end
  endtask

  function automatic logic [ENTRY_W-1:0] model_entry(input logic [7:0] d, input logic pen,
                                                     input logic podd, input logic pbit,
                                                     input logic stop);
    int ones;
    logic perr;
    ones = $countones({d, pbit});
    perr = pen && ((ones % 2) != int'(podd));
    return {perr, ~stop, d};
  endfunction

  initial begin
    bit ok;
    bit seen;
    int lat;
    int base;
    bit done;

    vecs[0] = '{8'h53, 1'b0, 1'b0, 1'b0, 1'b1, 87,  8'h53, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 87,  8'hA5, 1'b0, 1'b1};
    vecs[2] = '{8'h53, 1'b1, 1'b0, 1'b1, 1'b1, 87,  8'h53, 1'b1, 1'b0};
    vecs[3] = '{8'h53, 1'b1, 1'b0, 1'b0, 1'b1, 87,  8'h53, 1'b0, 1'b0};
    vecs[4] = '{8'h53, 1'b1, 1'b1, 1'b1, 1'b1, 87,  8'h53, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16,  8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 5,   8'hFF, 1'b0, 1'b1};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 3,   8'h80, 1'b0, 1'b0};
    vecs[8] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 200, 8'h01, 1'b0, 1'b0};
    vecs[9] = '{8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 10,  8'hC3, 1'b1, 1'b1};

    i_Presetn    = 1'b0;
    i_Baud       = 8'd16;
    i_Enable     = 1'b1;
    i_Parity_En  = 1'b0;
    i_Parity_Odd = 1'b0;
    i_Rx_Serial  = 1'b1;
    i_Ready      = 1'b0;

    repeat (3) @(negedge i_Pclk);
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_data", 32'(o_Data), 32'd0);
    check("rst_perr", 32'(o_Perr), 32'd0);
    check("rst_ferr", 32'(o_Ferr), 32'd0);
    check("rst_overrun", 32'(o_Overrun), 32'd0);
    check("rst_state", 32'(o_State), 32'(ST_IDLE));
    @(posedge i_Pclk);
    #1;
    i_Presetn = 1'b1;
    idle_cycles(5);

    // directed frame table
    for (int v = 0; v < 10; v++) begin
      i_Parity_En  = vecs[v].pen;
      i_Parity_Odd = vecs[v].podd;
      i_Baud       = 8'(vecs[v].baud);
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop, vecs[v].baud);
      idle_cycles(3 * vecs[v].baud);
      pop_expect($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
      @(negedge i_Pclk);
      check($sformatf("vec%0d_empty", v), 32'(o_Valid), 32'd0);
    end
    check("table_no_overrun", 32'(ovr_cnt), 32'd0);

    // latency from the start edge to o_Valid: about 9.5 bit times at 87 clocks/bit
    i_Parity_En = 1'b0;
    i_Baud      = 8'd87;
    lat = 0;
    fork
      send_frame(8'h53, 1'b0, 1'b0, 1'b1, 87);
      begin
        for (int n = 1; n <= 1200; n++) begin
          @(negedge i_Pclk);
          if (o_Valid) begin
            lat = n;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < 820 || lat > 840) begin
      errors++;
      $display("FAIL latency actual=%0d expected=820..840 cycles", lat);
    end
    idle_cycles(87);
    pop_expect("lat_frame", 8'h53, 1'b0, 1'b0);

    // short low pulse must be rejected as a glitch
    i_Rx_Serial = 1'b0;
    repeat (20) @(posedge i_Pclk);
    #1;
    i_Rx_Serial = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge i_Pclk);
      if (o_Valid) seen = 1'b1;
    end
    check("glitch_no_push", 32'(seen), 32'd0);
    check("glitch_state", 32'(o_State), 32'(ST_IDLE));

    // frame configuration changes after the start edge must not affect the frame
    i_Baud       = 8'd16;
    i_Parity_En  = 1'b1;
    i_Parity_Odd = 1'b1;
    fork
      send_frame(8'h52, 1'b1, 1'b0, 1'b1, 16);
      begin
        repeat (48) @(posedge i_Pclk);
        #1;
        i_Parity_En  = 1'b0;
        i_Parity_Odd = 1'b0;
        i_Baud       = 8'd40;
      end
    join
    idle_cycles(48);
    pop_expect("latched_cfg", 8'h52, 1'b0, 1'b0);
    i_Baud      = 8'd16;
    i_Parity_En = 1'b0;

    // disable mid-frame: partial frame discarded, FIFO contents kept
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(48);
    fork
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (80) @(posedge i_Pclk);
        #1;
        i_Enable = 1'b0;
        repeat (2) @(negedge i_Pclk);
        check("disable_state", 32'(o_State), 32'(ST_IDLE));
      end
    join
    idle_cycles(16);
    i_Enable = 1'b1;
    idle_cycles(32);
    pop_expect("disable_keep", 8'h11, 1'b0, 1'b0);
    @(negedge i_Pclk);
    check("disable_dropped", 32'(o_Valid), 32'd0);

    // reset during data bit 3 empties the FIFO and abandons the frame
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(48);
    @(negedge i_Pclk);
    check("prereset_valid", 32'(o_Valid), 32'd1);
    fork
      send_frame(8'hF0, 1'b0, 1'b0, 1'b1, 16);
      begin
        repeat (72) @(posedge i_Pclk);
        #1;
        i_Presetn = 1'b0;
        @(negedge i_Pclk);
        check("midrst_valid", 32'(o_Valid), 32'd0);
        check("midrst_data", 32'(o_Data), 32'd0);
        check("midrst_perr", 32'(o_Perr), 32'd0);
        check("midrst_ferr", 32'(o_Ferr), 32'd0);
        check("midrst_overrun", 32'(o_Overrun), 32'd0);
        check("midrst_state", 32'(o_State), 32'(ST_IDLE));
        repeat (16) @(posedge i_Pclk);
        #1;
        i_Presetn = 1'b1;
      end
    join
    idle_cycles(32);
    @(negedge i_Pclk);
    check("postrst_empty", 32'(o_Valid), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(48);
    pop_expect("postrst_frame", 8'h7E, 1'b0, 1'b0);
    @(negedge i_Pclk);
    check("postrst_only", 32'(o_Valid), 32'd0);

    // randomized frames with a randomly stalling consumer
    base = ovr_cnt;
    done = 1'b0;
    rand_mode = 1'b1;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          logic [7:0] d;
          logic pen, podd, pbit, stop;
          int baud;
          d    = 8'($urandom);
          pen  = 1'($urandom_range(0, 1));
          podd = 1'($urandom_range(0, 1));
          baud = $urandom_range(3, 16);
          pbit = (podd ? ~^d : ^d) ^ ($urandom_range(0, 3) == 0);
          stop = ($urandom_range(0, 7) != 0);
          i_Parity_En  = pen;
          i_Parity_Odd = podd;
          i_Baud       = 8'(baud);
          exp_q.push_back(model_entry(d, pen, podd, pbit, stop));
          send_frame(d, pen, pbit, stop, baud);
          idle_cycles(stop ? ($urandom_range(0, 2) * baud + 1) : 3 * baud);
        end
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(posedge i_Pclk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge i_Pclk);
          #1;
          i_Ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_Ready = 1'b0;
    @(negedge i_Pclk);
    rand_mode = 1'b0;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_no_overrun", 32'(ovr_cnt - base), 32'd0);

    // overrun: DEPTH frames held, the next one dropped with one pulse
    base = ovr_cnt;
    i_Parity_En = 1'b0;
    i_Baud      = 8'd16;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0, 1'b0, 1'b1, 16);
      idle_cycles(32);
    end
    @(negedge i_Pclk);
    check("full_no_overrun", 32'(ovr_cnt - base), 32'd0);
    check("full_valid", 32'(o_Valid), 32'd1);
    send_frame(8'h05, 1'b0, 1'b0, 1'b1, 16);
    idle_cycles(48);
    @(negedge i_Pclk);
    check("overrun_once", 32'(ovr_cnt - base), 32'd1);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovr_pop%0d", i), 8'(i), 1'b0, 1'b0);
    @(negedge i_Pclk);
    check("ovr_drained", 32'(o_Valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_deframer.md
RX_DEFRAMER -- requirements
Module: rx_deframer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, holding-FIFO entries (power of two, >=2).
REQ-002 SHALL have port i_Pclk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port i_Presetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_Baud  input  8  clocks per bit (87 = 115200 baud at 10 MHz); values below 2 are treated as 2.
REQ-005 SHALL have port i_Enable  input  1  receiver enable.
REQ-006 SHALL have port i_Parity_En  input  1  frame carries a parity bit after data.
REQ-007 SHALL have port i_Parity_Odd  input  1  1 = odd parity, 0 = even parity.
REQ-008 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port i_Ready  input  1  consumer accepts the FIFO head.
REQ-010 SHALL have port o_Valid  output  1  FIFO head is valid.
REQ-011 SHALL have port o_Data  output  8  head data byte.
REQ-012 SHALL have port o_Perr  output  1  head frame had a parity error.
REQ-013 SHALL have port o_Ferr  output  1  head frame had a stop-bit (framing) error.
REQ-014 SHALL have port o_Overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass i_Rx_Serial through a 2-flop synchronizer with reset value 1; all sampling uses the synchronized value.
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY and STOP, with a bit counter 0..i_Baud-1 and a 3-bit data index.
REQ-017 IDLE: on synchronized line = 0 with i_Enable = 1, SHALL go to START and clear the counter.
REQ-018 START: at counter = i_Baud>>1, SHALL go to DATA if the line is 0; otherwise it SHALL return to IDLE as a glitch with no push.
REQ-019 DATA: SHALL sample once every i_Baud clocks after the start sample, store LSB first, and after bit 7 go to PARITY if i_Parity_En = 1, else to STOP.
REQ-020 PARITY: SHALL sample once; o_Perr for the frame = XOR(data, sampled bit, i_Parity_Odd) != 0. Perr SHALL be 0 when parity is disabled.
REQ-021 STOP: SHALL sample once; a sampled 0 SHALL set Ferr; SHALL push {Perr, Ferr, data} and go to IDLE in the same cycle.
REQ-022 i_Parity_En, i_Parity_Odd and i_Baud SHALL be latched on the IDLE->START transition and held constant for the whole frame.
REQ-023 i_Enable = 0 SHALL force IDLE on the next edge, discard any partial frame, and keep the FIFO contents.
REQ-024 The FIFO SHALL be first-word-fall-through: o_Valid = not empty; pop occurs when o_Valid && i_Ready.
REQ-025 Data SHALL be visible on o_Valid the cycle after the stop sample.
REQ-026 A push into a full FIFO with no same-cycle pop SHALL drop the new frame and pulse o_Overrun for one cycle; push and pop in the same cycle when full SHALL accept the push.
REQ-027 Pointers SHALL wrap modulo DEPTH, with an extra bit distinguishing full from empty.

Reset
REQ-028 On i_Presetn = 0 the block SHALL asynchronously reset to: FSM IDLE, counters 0, synchronizer flops 1, FIFO empty, o_Valid 0, o_Data 0, o_Perr 0, o_Ferr 0, o_Overrun 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no push. After reset is released, reception SHALL resume on the next falling edge of the line.

Structure
REQ-030 Shared package usrt_pkg SHALL hold the FSM state enum, DATA_BITS = 8, and the FIFO entry width (10).
REQ-031 The FIFO SHALL be a separate sub-module rx_fifo, parameterized by WIDTH and DEPTH; the deframer FSM SHALL be in rx_deframer.

Verification
REQ-032 Baud = 87, parity off, send 0x53 with a good stop bit -> one entry: o_Data = 0x53, Perr = 0, Ferr = 0; o_Valid rises about 9.5 bit times after the start edge.
REQ-033 Line low for 20 clocks, then high (Baud = 87) -> no push, o_Valid stays 0, FSM back in IDLE.
REQ-034 Send 0xA5 with the stop bit forced to 0 -> o_Data = 0xA5, Ferr = 1.
REQ-035 Even parity, send 0x53 with parity bit 1 (correct value 0) -> Perr = 1; with parity bit 0 -> Perr = 0.
REQ-036 DEPTH = 4, i_Ready = 0, send 0x01..0x05 -> 4 entries held, o_Overrun pulses once at the 5th stop sample, then pops read 0x01..0x04 in order.
REQ-037 Assert i_Presetn low during data bit 3 of a frame, then send 0x7E -> only 0x7E appears, with all outputs 0 during reset.
